spi_master: RTL and testbench

- Memory-mapped SPI master (mode 0 only: CPOL=0, CPHA=0) that the core's MMIO path drives; its pins go straight to the user IO pads (spi_clk, spi_mosi, spi_miso).
- Sits directly downstream of the core's peripheral bus decode and upstream of the pad ring.
- Shifts 1..32 bits, MSB-first, at a programmable clock divider, full-duplex.
- Exposes a 3-register word interface with a 1-cycle registered read latency, matching the SRAM-style timing the core already handles.

---
 rtl/spi_pkg.sv | 21 ++
 rtl/spi_sync.sv | 23 ++
 rtl/spi_master.sv | 170 +++++++++++++++++
 tb/tb_spi_master.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Register map, CTRL/STATUS field positions and FSM encoding shared by the SPI master files.
package spi_pkg;

    localparam logic [1:0] SPI_DATA   = 2'd0;
    localparam logic [1:0] SPI_CTRL   = 2'd1;
    localparam logic [1:0] SPI_STATUS = 2'd2;

    localparam int unsigned CTRL_DIV_LSB = 0;
    localparam int unsigned CTRL_LEN_LSB = 8;
    localparam int unsigned CTRL_LEN_MSB = 12;

    localparam int unsigned STATUS_BUSY_BIT = 0;
    localparam int unsigned STATUS_OVR_BIT  = 1;

    typedef enum logic [1:0] {
        StIdle,
        StLow,
        StHigh
    } spi_state_e;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for a single asynchronous bit; reset clears the whole chain.
module spi_sync #(
    parameter int unsigned Stages = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [Stages-1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[Stages-2:0], d_i};
        end
    end

    assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI master with DATA/CTRL/STATUS registers and a registered, 1-cycle read port.
module spi_master
    import spi_pkg::*;
#(
    parameter int unsigned      DIV_W       = 8,
    parameter logic [DIV_W-1:0] RST_DIV     = DIV_W'(3),
    parameter int unsigned      SYNC_STAGES = 2
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        IN_we,
    input  logic        IN_re,
    input  logic [1:0]  IN_addr,
    input  logic [31:0] IN_wdata,
    output logic [31:0] OUT_rdata,
    output logic        OUT_busy,
    output logic        OUT_SPI_clk,
    output logic        OUT_SPI_mosi,
    input  logic        IN_SPI_miso
);

    spi_state_e       state_q, state_d;
    logic [DIV_W-1:0] hcnt_q, hcnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [4:0]       bcnt_q, bcnt_d;
    logic [4:0]       lenm1_q, lenm1_d;
    logic [31:0]      sr_q, sr_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             spi_clk_q, spi_clk_d;
    logic             mosi_q, mosi_d;
    logic             rxbit_q, rxbit_d;
    logic             ovr_q, ovr_d;

    logic             miso_s;
    logic             busy;
    logic             wr_data, wr_ctrl, wr_status;
    logic [31:0]      ctrl_rd, status_rd, rd_val;

    spi_sync #(
        .Stages(SYNC_STAGES)
    ) u_miso_sync (
        .clk_i(wb_clk_i),
        .rst_i(wb_rst_i),
        .d_i  (IN_SPI_miso),
        .q_o  (miso_s)
    );

    assign busy      = (state_q != StIdle);
    assign wr_data   = IN_we && (IN_addr == SPI_DATA);
    assign wr_ctrl   = IN_we && (IN_addr == SPI_CTRL);
    assign wr_status = IN_we && (IN_addr == SPI_STATUS);

    always_comb begin
        ctrl_rd = '0;
        ctrl_rd[CTRL_DIV_LSB +: DIV_W] = div_q;
        ctrl_rd[CTRL_LEN_MSB:CTRL_LEN_LSB] = lenm1_q;
        status_rd = '0;
        status_rd[STATUS_BUSY_BIT] = busy;
        status_rd[STATUS_OVR_BIT] = ovr_q;
        case (IN_addr)
            SPI_DATA:   rd_val = sr_q;
            SPI_CTRL:   rd_val = ctrl_rd;
            SPI_STATUS: rd_val = status_rd;
            default:    rd_val = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        hcnt_d    = hcnt_q;
        bcnt_d    = bcnt_q;
        sr_d      = sr_q;
        spi_clk_d = spi_clk_q;
        mosi_d    = mosi_q;
        rxbit_d   = rxbit_q;
        div_d     = div_q;
        lenm1_d   = lenm1_q;
        ovr_d     = ovr_q;
        rdata_d   = rdata_q;

        // Reads sample the pre-write state of every register.
        if (IN_re) begin
            rdata_d = rd_val;
        end
        if (wr_ctrl && !busy) begin
            div_d   = IN_wdata[CTRL_DIV_LSB +: DIV_W];
            lenm1_d = IN_wdata[CTRL_LEN_MSB:CTRL_LEN_LSB];
        end
        // Clear first so a coincident overrun still sets the flag.
        if (wr_status) begin
            ovr_d = 1'b0;
        end
        if (wr_data && busy) begin
            ovr_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (wr_data) begin
                    sr_d    = IN_wdata;
                    mosi_d  = IN_wdata[31];
                    hcnt_d  = div_q;
                    bcnt_d  = lenm1_q;
                    state_d = StLow;
                end
            end
            StLow: begin
                if (hcnt_q == '0) begin
                    spi_clk_d = 1'b1;
                    rxbit_d   = miso_s;
                    hcnt_d    = div_q;
                    state_d   = StHigh;
                end else begin
                    hcnt_d = hcnt_q - DIV_W'(1);
                end
            end
            StHigh: begin
                if (hcnt_q == '0) begin
                    spi_clk_d = 1'b0;
                    sr_d      = {sr_q[30:0], rxbit_q};
                    if (bcnt_q == '0) begin
                        state_d = StIdle;
                    end else begin
                        bcnt_d  = bcnt_q - 5'd1;
                        mosi_d  = sr_q[30];
                        hcnt_d  = div_q;
                        state_d = StLow;
                    end
                end else begin
                    hcnt_d = hcnt_q - DIV_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q   <= StIdle;
            hcnt_q    <= '0;
            bcnt_q    <= '0;
            sr_q      <= '0;
            spi_clk_q <= 1'b0;
            mosi_q    <= 1'b0;
            rxbit_q   <= 1'b0;
            div_q     <= RST_DIV;
            lenm1_q   <= 5'd7;
            ovr_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            hcnt_q    <= hcnt_d;
            bcnt_q    <= bcnt_d;
            sr_q      <= sr_d;
            spi_clk_q <= spi_clk_d;
            mosi_q    <= mosi_d;
            rxbit_q   <= rxbit_d;
            div_q     <= div_d;
            lenm1_q   <= lenm1_d;
            ovr_q     <= ovr_d;
            rdata_q   <= rdata_d;
        end
    end

    assign OUT_rdata    = rdata_q;
    assign OUT_busy     = busy;
    assign OUT_SPI_clk  = spi_clk_q;
    assign OUT_SPI_mosi = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Randomized bench for spi_master: register reads go through a scoreboard queue, and a
// cycle-scheduled slave model supplies MISO data.
module tb_spi_master;
    import spi_pkg::*;

    localparam int SYNC = 2;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b0;
    logic        IN_we = 1'b0;
    logic        IN_re = 1'b0;
    logic [1:0]  IN_addr = 2'd0;
    logic [31:0] IN_wdata = '0;
    logic [31:0] OUT_rdata;
    logic        OUT_busy;
    logic        OUT_SPI_clk;
    logic        OUT_SPI_mosi;
    logic        IN_SPI_miso;

    spi_master #(
        .DIV_W      (8),
        .RST_DIV    (8'd3),
        .SYNC_STAGES(SYNC)
    ) dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_i    (wb_rst_i),
        .IN_we       (IN_we),
        .IN_re       (IN_re),
        .IN_addr     (IN_addr),
        .IN_wdata    (IN_wdata),
        .OUT_rdata   (OUT_rdata),
        .OUT_busy    (OUT_busy),
        .OUT_SPI_clk (OUT_SPI_clk),
        .OUT_SPI_mosi(OUT_SPI_mosi),
        .IN_SPI_miso (IN_SPI_miso)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int n_checks = 0;
    int n_errors = 0;

    // Reference register state.
    int          m_div = 3;
    int          m_lenm1 = 7;
    logic        m_ovr = 1'b0;
    logic [31:0] m_data = '0;

    logic [31:0] exp_q[$];
    string       name_q[$];
    logic        re_seen = 1'b0;

    // Slave model state.
    int          edge_cnt = 0;
    int          start_cnt = 0;
    bit          slave_on = 0;
    bit          loopback = 0;
    logic [31:0] slave_word = '0;
    int          slave_len = 8;
    int          slave_div = 3;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endfunction

    function automatic logic [31:0] ctrl_val();
        return (32'(m_lenm1) << 8) | 32'(m_div);
    endfunction

    // Result of an N-bit shift: old TX bits move up by N, received bits fill [N-1:0].
    function automatic logic [31:0] xfer_result(input logic [31:0] tx, input logic [31:0] rx,
                                                input int n);
        logic [63:0] shifted;
        logic [63:0] mask;
        shifted = {32'b0, tx} << n;
        mask = (64'd1 << n) - 64'd1;
        return shifted[31:0] | (rx & mask[31:0]);
    endfunction

    always @(posedge wb_clk_i) begin
        edge_cnt <= edge_cnt + 1;
        re_seen  <= IN_re;
    end

    // Monitor: one registered read result per accepted read strobe.
    initial begin : monitor
        logic [31:0] e;
        string nm;
        forever begin
            @(negedge wb_clk_i);
            if (re_seen) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL rdata_unexpected: got 0x%08h, expected no read", OUT_rdata);
                end else begin
                    e = exp_q.pop_front();
                    nm = name_q.pop_front();
                    chk(nm, OUT_rdata, e);
                end
            end
        end
    end

    // Slave: bit k must be on MISO SYNC edges before the k-th rising SCLK edge, which lands
    // (2k+1)(div+1) edges after the DATA write.
    initial begin : slave
        int m;
        int k;
        IN_SPI_miso = 1'b0;
        forever begin
            @(negedge wb_clk_i);
            if (loopback) begin
                IN_SPI_miso = OUT_SPI_mosi;
            end else if (slave_on) begin
                m = edge_cnt - start_cnt;
                k = 0;
                while (k < slave_len && (2 * k + 1) * (slave_div + 1) - SYNC < m + 1) k++;
                if (k < slave_len) IN_SPI_miso = slave_word[slave_len-1-k];
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic rd(input logic [1:0] a, input logic [31:0] e, input string nm);
        @(negedge wb_clk_i);
        IN_re = 1'b1;
        IN_addr = a;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(negedge wb_clk_i);
        IN_re = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge wb_clk_i);
        IN_we = 1'b1;
        IN_addr = a;
        IN_wdata = d;
        @(negedge wb_clk_i);
        IN_we = 1'b0;
    endtask

    // inj: 0 none, 1 DATA write (overrun), 2 CTRL write, 3 STATUS/reserved reads while busy.
    task automatic run_xfer(input logic [31:0] tx, input logic [31:0] rx, input bit loop,
                            input int inj);
        int n, d, cyc, rises, r0, r1;
        logic [31:0] mosi_bits;
        logic prev_clk;
        n = m_lenm1 + 1;
        d = m_div;
        @(negedge wb_clk_i);
        loopback = loop;
        slave_word = rx;
        slave_len = n;
        slave_div = d;
        start_cnt = edge_cnt + 3;
        slave_on = 1;
        @(negedge wb_clk_i);
        @(negedge wb_clk_i);
        IN_we = 1'b1;
        IN_addr = SPI_DATA;
        IN_wdata = tx;
        @(negedge wb_clk_i);
        IN_we = 1'b0;
        cyc = 0;
        rises = 0;
        r0 = 0;
        r1 = 0;
        mosi_bits = '0;
        prev_clk = 1'b0;
        while (OUT_busy && cyc < 4000) begin
            if (OUT_SPI_clk && !prev_clk) begin
                if (rises == 0) r0 = cyc;
                if (rises == 1) r1 = cyc;
                rises++;
                mosi_bits = {mosi_bits[30:0], OUT_SPI_mosi};
            end
            prev_clk = OUT_SPI_clk;
            IN_we = 1'b0;
            IN_re = 1'b0;
            if (inj == 1 && cyc == 10) begin
                IN_we = 1'b1;
                IN_addr = SPI_DATA;
                IN_wdata = 32'h1234_5678;
                m_ovr = 1'b1;
            end else if (inj == 2 && cyc == 10) begin
                IN_we = 1'b1;
                IN_addr = SPI_CTRL;
                IN_wdata = 32'h0000_0709;
            end else if (inj == 3 && cyc == 10) begin
                IN_re = 1'b1;
                IN_addr = SPI_STATUS;
                exp_q.push_back({30'b0, m_ovr, 1'b1});
                name_q.push_back("status_busy_read");
            end else if (inj == 3 && cyc == 12) begin
                IN_re = 1'b1;
                IN_addr = 2'd3;
                exp_q.push_back(32'h0);
                name_q.push_back("reserved_read");
            end
            cyc++;
            @(negedge wb_clk_i);
        end
        IN_we = 1'b0;
        IN_re = 1'b0;
        slave_on = 0;
        loopback = 0;
        chk("busy_cycles", 32'(cyc), 32'(n * 2 * (d + 1)));
        chk("sclk_rises", 32'(rises), 32'(n));
        chk("mosi_sequence", mosi_bits, tx >> (32 - n));
        chk("sclk_idle_low", {31'b0, OUT_SPI_clk}, 32'h0);
        chk("mosi_hold_last", {31'b0, OUT_SPI_mosi}, {31'b0, tx[32-n]});
        if (n >= 2) chk("sclk_period", 32'(r1 - r0), 32'(2 * (d + 1)));
        m_data = xfer_result(tx, loop ? (tx >> (32 - n)) : rx, n);
    endtask

    initial begin : stim
        logic [31:0] tx, rx, w;
        int rises, guard;
        logic prev_clk;

        wb_rst_i = 1'b1;
        repeat (2) @(negedge wb_clk_i);
        chk("rst_rdata", OUT_rdata, 32'h0);
        chk("rst_busy", {31'b0, OUT_busy}, 32'h0);
        chk("rst_sclk", {31'b0, OUT_SPI_clk}, 32'h0);
        chk("rst_mosi", {31'b0, OUT_SPI_mosi}, 32'h0);
        wb_rst_i = 1'b0;
        rd(SPI_CTRL, ctrl_val(), "rst_ctrl");
        rd(SPI_STATUS, 32'h0, "rst_status");
        rd(SPI_DATA, 32'h0, "rst_data");

        // Loopback byte with default CTRL, plus reads while busy.
        run_xfer(32'hA500_0000, 32'h0, 1'b1, 3);
        rd(SPI_DATA, m_data, "loopback_data");

        // 32-bit transfer at the fastest divider.
        wr(SPI_CTRL, 32'h0000_1F00);
        m_div = 0;
        m_lenm1 = 31;
        run_xfer($urandom(), 32'hDEAD_BEEF, 1'b0, 0);
        rd(SPI_DATA, m_data, "div0_data");

        // Restore defaults for the overrun and busy-CTRL checks.
        wr(SPI_CTRL, 32'h0000_0703);
        m_div = 3;
        m_lenm1 = 7;
        run_xfer($urandom(), $urandom(), 1'b0, 1);
        rd(SPI_DATA, m_data, "overrun_data");
        rd(SPI_STATUS, {30'b0, m_ovr, 1'b0}, "overrun_status");
        wr(SPI_STATUS, $urandom());
        m_ovr = 1'b0;
        rd(SPI_STATUS, 32'h0, "overrun_cleared");

        run_xfer($urandom(), $urandom(), 1'b0, 2);
        rd(SPI_CTRL, ctrl_val(), "ctrl_busy_ignored");

        // Random configurations; each CTRL write is paired with a same-cycle CTRL read.
        for (int i = 0; i < 6; i++) begin
            w = $urandom() & 32'hFFFF_E000;
            @(negedge wb_clk_i);
            IN_we = 1'b1;
            IN_re = 1'b1;
            IN_addr = SPI_CTRL;
            exp_q.push_back(ctrl_val());
            name_q.push_back("ctrl_read_during_write");
            m_div = $urandom_range(0, 4);
            m_lenm1 = $urandom_range(0, 31);
            IN_wdata = w | ctrl_val();
            @(negedge wb_clk_i);
            IN_we = 1'b0;
            IN_re = 1'b0;
            tx = $urandom();
            rx = $urandom();
            run_xfer(tx, rx, 1'b0, 0);
            rd(SPI_DATA, m_data, "random_data");
        end
        rd(SPI_STATUS, 32'h0, "random_status");

        // Reset in the high phase of the third bit.
        wr(SPI_CTRL, 32'h0000_0F05);
        m_div = 5;
        m_lenm1 = 15;
        wr(SPI_DATA, $urandom() | 32'h2000_0000);
        rises = 0;
        guard = 0;
        prev_clk = 1'b0;
        while (rises < 3 && guard < 2000) begin
            @(negedge wb_clk_i);
            if (OUT_SPI_clk && !prev_clk) rises++;
            prev_clk = OUT_SPI_clk;
            guard++;
        end
        chk("pre_reset_sclk", {31'b0, OUT_SPI_clk}, 32'h1);
        chk("pre_reset_mosi", {31'b0, OUT_SPI_mosi}, 32'h1);
        #2;
        wb_rst_i = 1'b1;
        #1;
        chk("mid_rst_sclk", {31'b0, OUT_SPI_clk}, 32'h0);
        chk("mid_rst_mosi", {31'b0, OUT_SPI_mosi}, 32'h0);
        chk("mid_rst_busy", {31'b0, OUT_busy}, 32'h0);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        m_div = 3;
        m_lenm1 = 7;
        m_ovr = 1'b0;
        rd(SPI_CTRL, ctrl_val(), "mid_rst_ctrl");
        rd(SPI_DATA, 32'h0, "mid_rst_data");
        rd(SPI_STATUS, 32'h0, "mid_rst_status");

        repeat (3) @(negedge wb_clk_i);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL pending_reads: got %0d outstanding, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
